ntt_twiddle_sequencer: RTL and testbench
========================================

# ntt_twiddle_sequencer

Issue sequencer for one radix-2 Cooley-Tukey NTT/INTT pass over an N = 2^LOG_N coefficient array. It walks stage/group/butterfly counters and drives the address of the twiddle ROM (`single_port_rom`, 2-cycle registered read, forward table at 0..N-1, inverse table at N..2N-1). It delays the butterfly coefficient indices by the ROM latency, so the downstream butterfly unit receives the index pair and the twiddle word in the same cycle.

## Interface
Parameters:
- LOG_N, 10, log2 of transform size N
- ADDR_WIDTH, 12, ROM address width; must satisfy ADDR_WIDTH ≥ LOG_N+1
- ROM_LAT, 2, ROM read latency in cycles
- STAGE_GAP, 4, idle cycles inserted between stages for the memory-write hazard; 0 is legal

Ports:
- clk, in, 1, clock; all state on rising edge
- rst, in, 1, asynchronous active-high reset
- start, in, 1, one-cycle request; accepted only when busy=0
- inverse, in, 1, sampled with start; 1 selects the inverse table (offset N)
- rom_addr, out, ADDR_WIDTH, registered twiddle address to the ROM
- bf_valid, out, 1, index pair and ROM data valid this cycle
- bf_idx_a, out, LOG_N, first coefficient index
- bf_idx_b, out, LOG_N, second coefficient index (= a + len)
- busy, out, 1, high from start acceptance through the done cycle
- done, out, 1, one-cycle pulse coincident with the last bf_valid

## Operation
- States: IDLE, RUN, GAP, DRAIN.
- **IDLE**
  - If start=1, latch inverse, clear s/g/j, and go to RUN.
  - The first issue is registered on this same edge.
- **RUN**: one butterfly issue per cycle.
  - m = 2^s; len = N >> (s+1).
  - idx_a = (g << (LOG_N−s)) + j; idx_b = idx_a + len.
  - rom_addr = (inverse ? N : 0) + m + g, so k runs 1..N−1.
  - Inner loop j over 0..len−1, then g over 0..m−1, then s over 0..LOG_N−1.
- After the last butterfly of stage s < LOG_N−1:
  - Go to GAP for STAGE_GAP cycles with no issue, then back to RUN.
  - With STAGE_GAP=0, stages issue back-to-back.
- After the last butterfly of the last stage, go to DRAIN for ROM_LAT cycles, then to IDLE.
- Total issues: LOG_N·N/2. Index arithmetic is unsigned and never exceeds N−1.
- rom_addr holds its last value when not issuing. The ROM has no enable, so this is harmless.
- start while busy=1 is ignored, including during the done cycle. inverse is ignored except at acceptance.

## Timing
- **Reset values**: rom_addr=0, bf_valid=0, bf_idx_a=0, bf_idx_b=0, busy=0, done=0, state=IDLE, delay line cleared.
- **Reset mid-operation** aborts immediately; no done is produced.
- **Acceptance**: start is sampled at edge E0. busy=1 and rom_addr = first address after E0.
- **Issue timing**
  - Issue i (counted including gap bubbles) is registered at edge E0+i.
  - bf_valid/idx for that issue appear ROM_LAT edges later, aligned with the ROM `read` output.
- **Delay line**: ROM_LAT stages of {valid, idx_a, idx_b}. Bubbles propagate as valid=0.
- **done**: high exactly in the cycle the final bf_valid is high.
- **busy**: drops at the following edge. A new start is accepted at the earliest one cycle after done.
- **Run length**: the last bf_valid falls E0 + LOG_N·N/2 + (LOG_N−1)·STAGE_GAP + ROM_LAT − 1 edges after acceptance.

## Structure
- Shared include `ntt_params.vh` holds:
  - state encodings (IDLE=0, RUN=1, GAP=2, DRAIN=3)
  - default LOG_N and ADDR_WIDTH
  - forward/inverse table offset convention
- Sub-module `pipe_delay` (params WIDTH, DEPTH, async active-high reset to 0) implements the ROM_LAT alignment line. It is reusable for other ROM-aligned paths.

## Test plan
- **Forward sequence**: LOG_N=3, STAGE_GAP=0, start with inverse=0. Required bf stream (a,b,k), with ROM preloaded read=addr:
  - (0,4,1)(1,5,1)(2,6,1)(3,7,1)
  - (0,2,2)(1,3,2)(4,6,3)(5,7,3)
  - (0,1,4)(2,3,5)(4,5,6)(6,7,7)
  - 12 valids contiguous; done on the 12th.
- **Inverse offset**: same setup with inverse=1 → identical a/b, and k values 9,9,9,9,10,10,11,11,12,13,14,15.
- **Stage gaps**: LOG_N=3, STAGE_GAP=2 → exactly two valid=0 cycles after the 4th and after the 8th valid. busy=1 for 12+4+ROM_LAT−… cycles, matching the Timing formula.
- **Start while busy**: start pulsed mid-run and again in the done cycle → both ignored, stream unchanged. Start one cycle after done → accepted, new run identical.
- **Reset mid-operation**: rst asserted after the 5th valid → all outputs 0 asynchronously, no done. Next start gives the full 12-butterfly stream from (0,4,1).
- **Full size**: LOG_N=10, ADDR_WIDTH=12 → 5120 valids. Last pair (1022,1023) with k=1023 (forward) or 2047 (inverse), and a single done.

Source files
------------

// File: rtl/ntt_twiddle_sequencer_pkg.sv
// Shared definitions for the NTT twiddle sequencer: FSM state encoding,
// default sizing and the forward/inverse twiddle table placement.
package ntt_twiddle_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_e;

    localparam int DEFAULT_LOG_N      = 10;
    localparam int DEFAULT_ADDR_WIDTH = 12;
    localparam int DEFAULT_ROM_LAT    = 2;
    localparam int DEFAULT_STAGE_GAP  = 4;

    // Forward twiddles live at 0..N-1, inverse twiddles at N..2N-1.
    function automatic int unsigned table_base(input logic inv, input int unsigned log_n);
        return inv ? (32'd1 << log_n) : 32'd0;
    endfunction

endpackage

// File: rtl/ntt_twiddle_sequencer_pipe_delay.sv
// Fixed-depth register delay line with asynchronous clear, used to align
// side-band data with a registered ROM read.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/ntt_twiddle_sequencer.sv
// Issue sequencer for one radix-2 NTT/INTT pass: walks stage/group/butterfly
// counters, addresses the twiddle ROM and delays the index pair to match it.
module ntt_twiddle_sequencer
    import ntt_twiddle_sequencer_pkg::*;
#(
    parameter int LOG_N      = DEFAULT_LOG_N,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ROM_LAT    = DEFAULT_ROM_LAT,
    parameter int STAGE_GAP  = DEFAULT_STAGE_GAP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  inverse,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  bf_valid,
    output logic [LOG_N-1:0]      bf_idx_a,
    output logic [LOG_N-1:0]      bf_idx_b,
    output logic                  busy,
    output logic                  done
);

    localparam int S_W     = $clog2(LOG_N + 1);
    localparam int CNT_MAX = (STAGE_GAP > ROM_LAT) ? STAGE_GAP : ROM_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PIPE_W  = 2 + 2 * LOG_N;
    localparam logic [LOG_N-1:0] HALF_N = LOG_N'(1 << (LOG_N - 1));

    seq_state_e            state_q, state_d;
    logic [S_W-1:0]        s_q, s_d;
    logic [LOG_N-1:0]      g_q, g_d;
    logic [LOG_N-1:0]      j_q, j_d;
    logic                  inv_q, inv_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  iss_valid_q, iss_valid_d;
    logic                  iss_last_q, iss_last_d;
    logic [LOG_N-1:0]      iss_a_q, iss_a_d;
    logic [LOG_N-1:0]      iss_b_q, iss_b_d;

    logic                  accept;
    logic                  issue;
    logic [S_W-1:0]        cur_s;
    logic [LOG_N-1:0]      cur_g;
    logic [LOG_N-1:0]      cur_j;
    logic                  cur_inv;
    logic [LOG_N-1:0]      len;
    logic [LOG_N-1:0]      m;
    logic [LOG_N-1:0]      idx_a;
    logic                  last_j;
    logic                  last_g;
    logic                  last_s;
    logic [PIPE_W-1:0]     pipe_out;

    // The accepting edge issues the first butterfly, so the counters are
    // bypassed to zero rather than waiting a cycle for them to clear.
    assign accept  = (state_q == ST_IDLE) && start && !busy_q;
    assign issue   = accept || (state_q == ST_RUN);
    assign cur_s   = accept ? '0 : s_q;
    assign cur_g   = accept ? '0 : g_q;
    assign cur_j   = accept ? '0 : j_q;
    assign cur_inv = accept ? inverse : inv_q;

    assign len    = HALF_N >> cur_s;
    assign m      = LOG_N'(1) << cur_s;
    assign idx_a  = (cur_g << (S_W'(LOG_N) - cur_s)) + cur_j;
    assign last_j = (cur_j == len - LOG_N'(1));
    assign last_g = (cur_g == m - LOG_N'(1));
    assign last_s = (cur_s == S_W'(LOG_N - 1));

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        g_d         = g_q;
        j_d         = j_q;
        inv_d       = inv_q;
        cnt_d       = cnt_q;
        rom_addr_d  = rom_addr_q;
        iss_valid_d = 1'b0;
        iss_last_d  = 1'b0;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        busy_d      = accept ? 1'b1 : (done ? 1'b0 : busy_q);

        if (accept) begin
            inv_d = inverse;
        end

        case (state_q)
            ST_GAP: begin
                if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(ROM_LAT - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        // Loop nest: j innermost, then group g, then stage s.
        if (issue) begin
            iss_valid_d = 1'b1;
            iss_a_d     = idx_a;
            iss_b_d     = idx_a + len;
            rom_addr_d  = ADDR_WIDTH'(table_base(cur_inv, LOG_N))
                        + ADDR_WIDTH'(m) + ADDR_WIDTH'(cur_g);
            state_d     = ST_RUN;
            s_d         = cur_s;
            g_d         = cur_g;
            j_d         = cur_j + LOG_N'(1);
            if (last_j) begin
                j_d = '0;
                g_d = cur_g + LOG_N'(1);
                if (last_g) begin
                    g_d = '0;
                    s_d = cur_s + S_W'(1);
                    if (last_s) begin
                        state_d    = ST_DRAIN;
                        iss_last_d = 1'b1;
                        cnt_d      = '0;
                    end else if (STAGE_GAP > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            g_q         <= '0;
            j_q         <= '0;
            inv_q       <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            rom_addr_q  <= '0;
            iss_valid_q <= 1'b0;
            iss_last_q  <= 1'b0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            g_q         <= g_d;
            j_q         <= j_d;
            inv_q       <= inv_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            rom_addr_q  <= rom_addr_d;
            iss_valid_q <= iss_valid_d;
            iss_last_q  <= iss_last_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
        end
    end

    // The last-issue flag rides the delay line and becomes done directly.
    pipe_delay #(
        .WIDTH (PIPE_W),
        .DEPTH (ROM_LAT)
    ) u_align (
        .clk  (clk),
        .rst  (rst),
        .din  ({iss_last_q, iss_valid_q, iss_a_q, iss_b_q}),
        .dout (pipe_out)
    );

    assign {done, bf_valid, bf_idx_a, bf_idx_b} = pipe_out;
    assign busy     = busy_q;
    assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_ntt_twiddle_sequencer.sv
// Self-checking bench for ntt_twiddle_sequencer: spec vector table, loop-nest
// reference model with randomized runs, busy/start/reset corner sequences.
module tb_ntt_twiddle_sequencer;

    typedef struct {
        bit v;
        int a;
        int b;
        int k;
    } issue_t;

    typedef struct {
        bit inv;
        int a;
        int b;
        int k;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic inverse = 1'b0;
    int   sel = 0;

    logic       start0, start1, start2;
    logic [3:0] addr0, addr1;
    logic [11:0] addr2;
    logic       v0, v1, v2, busy0, busy1, busy2, done0, done1, done2;
    logic [2:0] a0, b0, a1, b1;
    logic [9:0] a2, b2;

    logic [11:0] mon_addr;
    logic        mon_valid, mon_busy, mon_done;
    logic [9:0]  mon_a, mon_b;
    logic [11:0] rom_p1, rom_p2;

    int     checks = 0;
    int     errors = 0;
    int     done_seen;
    vec_t   vecs[24];
    issue_t exp_q[$];
    issue_t obs_q[$];

    always #5 clk = ~clk;

    ntt_twiddle_sequencer #(.LOG_N(3), .ADDR_WIDTH(4), .ROM_LAT(2), .STAGE_GAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .inverse(inverse), .rom_addr(addr0),
        .bf_valid(v0), .bf_idx_a(a0), .bf_idx_b(b0), .busy(busy0), .done(done0));

    ntt_twiddle_sequencer #(.LOG_N(3), .ADDR_WIDTH(4), .ROM_LAT(2), .STAGE_GAP(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .inverse(inverse), .rom_addr(addr1),
        .bf_valid(v1), .bf_idx_a(a1), .bf_idx_b(b1), .busy(busy1), .done(done1));

    ntt_twiddle_sequencer #(.LOG_N(10), .ADDR_WIDTH(12), .ROM_LAT(2), .STAGE_GAP(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .inverse(inverse), .rom_addr(addr2),
        .bf_valid(v2), .bf_idx_a(a2), .bf_idx_b(b2), .busy(busy2), .done(done2));

    always_comb begin
        start0    = start && (sel == 0);
        start1    = start && (sel == 1);
        start2    = start && (sel == 2);
        mon_addr  = 12'(addr0);
        mon_valid = v0;
        mon_a     = 10'(a0);
        mon_b     = 10'(b0);
        mon_busy  = busy0;
        mon_done  = done0;
        if (sel == 1) begin
            mon_addr  = 12'(addr1);
            mon_valid = v1;
            mon_a     = 10'(a1);
            mon_b     = 10'(b1);
            mon_busy  = busy1;
            mon_done  = done1;
        end else if (sel == 2) begin
            mon_addr  = addr2;
            mon_valid = v2;
            mon_a     = a2;
            mon_b     = b2;
            mon_busy  = busy2;
            mon_done  = done2;
        end
    end

    // Twiddle ROM stand-in: 2-cycle registered read returning its own address.
    always_ff @(posedge clk) begin
        rom_p1 <= mon_addr;
        rom_p2 <= rom_p1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: plain stage/group/butterfly loop nest with bubbles between stages.
    function automatic void build_model(input int log_n, input int gap, input bit inv);
        int n;
        n = 1 << log_n;
        exp_q.delete();
        for (int s = 0; s < log_n; s++) begin
            int mm;
            int ln;
            mm = 1 << s;
            ln = n / (2 * mm);
            for (int g = 0; g < mm; g++) begin
                for (int j = 0; j < ln; j++) begin
                    exp_q.push_back('{1'b1, g * 2 * ln + j, g * 2 * ln + j + ln, (inv ? n : 0) + mm + g});
                end
            end
            if (s < log_n - 1) begin
                for (int z = 0; z < gap; z++) exp_q.push_back('{1'b0, 0, 0, 0});
            end
        end
    endfunction

    task automatic checkReset();
        checkOutput("reset_rom_addr", int'(mon_addr), 0);
        checkOutput("reset_bf_valid", int'(mon_valid), 0);
        checkOutput("reset_bf_idx_a", int'(mon_a), 0);
        checkOutput("reset_bf_idx_b", int'(mon_b), 0);
        checkOutput("reset_busy", int'(mon_busy), 0);
        checkOutput("reset_done", int'(mon_done), 0);
    endtask

    task automatic abortRun();
        #1 rst = 1'b1;
        #1 checkReset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 checkOutput("reset_no_done", int'(mon_done), 0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One run on instance `which`; poke pulses start mid-run and in the done
    // cycle; abort_after>0 asserts reset after that many valids.
    task automatic applyStimulus(input int which, input bit inv, input bit poke, input int abort_after);
        int log_n, gap, n, t_tot, nvalid;
        issue_t e;
        sel   = which;
        log_n = (which == 2) ? 10 : 3;
        gap   = (which == 0) ? 0 : ((which == 1) ? 2 : 4);
        n     = 1 << log_n;
        build_model(log_n, gap, inv);
        t_tot = exp_q.size();
        obs_q.delete();
        done_seen = 0;
        nvalid    = 0;
        @(negedge clk);
        start   = 1'b1;
        inverse = inv;
        @(posedge clk);
        #1;
        start   = 1'b0;
        inverse = 1'($urandom_range(0, 1));
        checkOutput("accept_busy", int'(mon_busy), 1);
        checkOutput("first_rom_addr", int'(mon_addr), (inv ? n : 0) + 1);
        for (int c = 1; c <= t_tot + 2; c++) begin
            start = poke && (c == t_tot / 2 || c == t_tot + 2);
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c >= 2 && c - 2 < t_tot) e = exp_q[c-2];
            else e = '{1'b0, 0, 0, 0};
            checkOutput("bf_valid", int'(mon_valid), int'(e.v));
            if (mon_valid) obs_q.push_back('{1'b1, int'(mon_a), int'(mon_b), int'(rom_p2)});
            if (e.v) begin
                nvalid++;
                checkOutput("bf_idx_a", int'(mon_a), e.a);
                checkOutput("bf_idx_b", int'(mon_b), e.b);
                checkOutput("rom_k", int'(rom_p2), e.k);
            end
            checkOutput("done", int'(mon_done), int'(c == t_tot + 1));
            checkOutput("busy", int'(mon_busy), int'(c <= t_tot + 1));
            if (mon_done) done_seen++;
            if (abort_after > 0 && nvalid == abort_after) begin
                abortRun();
                return;
            end
        end
        checkOutput("done_count", done_seen, 1);
    endtask

    initial begin
        int fa[12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
        int fb[12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
        int fk[12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
        int ik[12] = '{9, 9, 9, 9, 10, 10, 11, 11, 12, 13, 14, 15};
        for (int i = 0; i < 12; i++) begin
            vecs[i]      = '{1'b0, fa[i], fb[i], fk[i]};
            vecs[12 + i] = '{1'b1, fa[i], fb[i], ik[i]};
        end

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        for (int w = 0; w < 3; w++) begin
            sel = w;
            #1 checkReset();
        end
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 2; r++) begin
            applyStimulus(0, r[0], 1'b0, 0);
            checkOutput("vec_count", obs_q.size(), 12);
            for (int i = 0; i < 12; i++) begin
                if (i < obs_q.size()) begin
                    checkOutput("vec_a", obs_q[i].a, vecs[r * 12 + i].a);
                    checkOutput("vec_b", obs_q[i].b, vecs[r * 12 + i].b);
                    checkOutput("vec_k", obs_q[i].k, vecs[r * 12 + i].k);
                end
            end
        end

        applyStimulus(1, 1'b0, 1'b0, 0);

        applyStimulus(0, 1'b0, 1'b1, 0);
        applyStimulus(0, 1'b0, 1'b0, 0);

        applyStimulus(0, 1'b0, 1'b0, 5);
        applyStimulus(0, 1'b0, 1'b0, 0);
        checkOutput("post_reset_count", obs_q.size(), 12);
        if (obs_q.size() > 0) begin
            checkOutput("post_reset_first_a", obs_q[0].a, 0);
            checkOutput("post_reset_first_b", obs_q[0].b, 4);
            checkOutput("post_reset_first_k", obs_q[0].k, 1);
        end

        for (int r = 0; r < 12; r++) begin
            int which, abort_n;
            bit inv, poke;
            which   = $urandom_range(0, 1);
            inv     = 1'($urandom_range(0, 1));
            poke    = 1'($urandom_range(0, 1));
            abort_n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 11) : 0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(which, inv, poke, abort_n);
        end

        for (int r = 0; r < 2; r++) begin
            applyStimulus(2, r[0], 1'b0, 0);
            checkOutput("full_count", obs_q.size(), 5120);
            if (obs_q.size() > 0) begin
                checkOutput("full_last_a", obs_q[obs_q.size()-1].a, 1022);
                checkOutput("full_last_b", obs_q[obs_q.size()-1].b, 1023);
                checkOutput("full_last_k", obs_q[obs_q.size()-1].k, (r == 0) ? 1023 : 2047);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
